sfx_trigger_sequencer: RTL and testbench

- Upstream stage of the APU snare voice.
- Collects one-shot sound-effect requests from game logic (collisions, pickups, deaths, etc.), queues them, and issues well-formed snare_trigger pulses to the APU.
- Pulses are timed on the video scanline/frame grid, so that each snare fully decays before the next starts and no request is lost to the APU's busy window.

---
 rtl/sfx_trigger_sequencer.sv | 148 ++++++++++++++
 tb/tb_sfx_trigger_sequencer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sfx_trigger_sequencer.sv
// Queues one-shot sound-effect requests and issues scanline/frame-timed snare_trigger pulses.
// Optional build macro SFX_COALESCE_EN: merge bursts into one pending request, no overflow.
module sfx_trigger_sequencer #(
  parameter int NUM_SRC     = 4,
  parameter int QUEUE_DEPTH = 4,
  parameter int HOLD_LINES  = 4,
  parameter int GAP_FRAMES  = 12
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] event_req,
  input  logic               frame_end,
  input  logic [9:0]         pix_x,
  output logic               snare_trigger,
  output logic [2:0]         pending_count,
  output logic               busy,
  output logic               overflow
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  localparam logic [7:0] HOLD_L = 8'(HOLD_LINES);
  localparam logic [7:0] GAP_F  = 8'(GAP_FRAMES);
`ifdef SFX_COALESCE_EN
  localparam logic [7:0] QMAX   = 8'd1;
`else
  localparam logic [7:0] QMAX   = 8'(QUEUE_DEPTH);
`endif

  state_t             state_q, state_d;
  logic [NUM_SRC-1:0] prev_req_q;
  logic [NUM_SRC-1:0] new_edges;
  logic [2:0]         pending_q, pending_d;
  logic [7:0]         line_q, line_d;
  logic [7:0]         frame_q, frame_d;
  logic               trig_q, trig_d;
  logic               deq;
  logic [7:0]         add;
  logic [7:0]         add_eff;
  logic [7:0]         sum;

  always_comb begin
    new_edges = event_req & ~prev_req_q;
    add = 8'd0;
    for (int i = 0; i < NUM_SRC; i++) begin
      add = add + 8'(new_edges[i]);
    end
  end

  // Line and frame counters only advance in their own state, so no event ever double-counts.
  always_comb begin
    state_d = state_q;
    line_d  = line_q;
    frame_d = frame_q;
    trig_d  = trig_q;
    deq     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pending_q != 3'd0) begin
          state_d = S_HOLD;
          trig_d  = 1'b1;
          line_d  = 8'd0;
          deq     = 1'b1;
        end
      end
      S_HOLD: begin
        if (pix_x == 10'd0) begin
          line_d = line_q + 8'd1;
          if (line_q + 8'd1 == HOLD_L) begin
            state_d = S_GAP;
            trig_d  = 1'b0;
            frame_d = 8'd0;
          end
        end
      end
      S_GAP: begin
        if (frame_end) begin
          frame_d = frame_q + 8'd1;
          if (frame_q + 8'd1 == GAP_F) begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        trig_d  = 1'b0;
      end
    endcase
  end

  always_comb begin
    add_eff = add;
`ifdef SFX_COALESCE_EN
    if (state_q == S_HOLD) begin
      add_eff = 8'd0;
    end
`endif
    sum = {5'd0, pending_q} + add_eff - {7'd0, deq};
    if (sum > QMAX) begin
      pending_d = QMAX[2:0];
    end else begin
      pending_d = sum[2:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      prev_req_q <= '0;
      pending_q  <= 3'd0;
      line_q     <= 8'd0;
      frame_q    <= 8'd0;
      trig_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      prev_req_q <= event_req;
      pending_q  <= pending_d;
      line_q     <= line_d;
      frame_q    <= frame_d;
      trig_q     <= trig_d;
    end
  end

`ifdef SFX_COALESCE_EN
  assign overflow = 1'b0;
`else
  logic ovf_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= (sum > QMAX);
    end
  end

  assign overflow = ovf_q;
`endif

  assign snare_trigger = trig_q;
  assign pending_count = pending_q;
  assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_sfx_trigger_sequencer.sv
// Directed vector bench for sfx_trigger_sequencer with default parameters (HOLD 4 lines, GAP 12 frames, depth 4).
module tb_sfx_trigger_sequencer;

  logic       clk;
  logic       reset;
  logic [3:0] event_req;
  logic       frame_end;
  logic [9:0] pix_x;
  logic       snare_trigger;
  logic [2:0] pending_count;
  logic       busy;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  int   pulse_cnt = 0;
  int   ovf_cnt   = 0;
  int   max_pend  = 0;
  logic trig_prev = 1'b0;

  typedef struct {
    logic [3:0] req;
    logic       fe;
    logic       lz;
    logic       trig;
    logic [2:0] pend;
    logic       busy;
    logic       ovf;
  } vec_t;

  vec_t tbl[$];

  sfx_trigger_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .event_req     (event_req),
    .frame_end     (frame_end),
    .pix_x         (pix_x),
    .snare_trigger (snare_trigger),
    .pending_count (pending_count),
    .busy          (busy),
    .overflow      (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (snare_trigger && !trig_prev) pulse_cnt++;
    trig_prev = snare_trigger;
    if (overflow) ovf_cnt++;
    if (int'(pending_count) > max_pend) max_pend = int'(pending_count);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input logic [3:0] r, input logic fe, input logic lz);
    event_req = r;
    frame_end = fe;
    pix_x     = lz ? 10'd0 : 10'd5;
    @(posedge clk);
    #1;
  endtask

  function automatic void addv(input logic [3:0] r, input logic fe, input logic lz,
                               input logic tr, input logic [2:0] pe, input logic bu, input logic ov);
    vec_t v;
    v.req = r; v.fe = fe; v.lz = lz;
    v.trig = tr; v.pend = pe; v.busy = bu; v.ovf = ov;
    tbl.push_back(v);
  endfunction

  task automatic issue(input logic [3:0] r, input int exp_pend);
    step(r, 1'b0, 1'b0);
    chk("issue trig", snare_trigger, 1);
    chk("issue pend", pending_count, exp_pend);
    chk("issue busy", busy, 1);
  endtask

  task automatic pulse_body(input logic [3:0] r);
    for (int l = 1; l <= 4; l++) begin
      step(r, 1'b0, 1'b1);
      chk($sformatf("hold line%0d trig", l), snare_trigger, (l < 4) ? 1 : 0);
    end
    for (int f = 1; f <= 12; f++) begin
      step(r, 1'b1, 1'b0);
      chk($sformatf("gap frame%0d busy", f), busy, (f < 12) ? 1 : 0);
    end
  endtask

  initial begin
    int p0;
    int o0;

    reset     = 1'b1;
    event_req = 4'b0000;
    frame_end = 1'b0;
    pix_x     = 10'd5;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("reset trig", snare_trigger, 0);
    chk("reset pend", pending_count, 0);
    chk("reset busy", busy, 0);
    chk("reset ovf", overflow, 0);
    reset = 1'b0;

    // Single request; frame_end/pix_x ignored in the wrong states; second request arrives mid-GAP.
    addv(4'b0000, 1, 1, 0, 0, 0, 0);
    addv(4'b0001, 0, 0, 0, 1, 0, 0);
    addv(4'b0001, 0, 0, 1, 0, 1, 0);
    addv(4'b0001, 0, 1, 1, 0, 1, 0);
    addv(4'b0001, 1, 1, 1, 0, 1, 0);
    addv(4'b0000, 1, 0, 1, 0, 1, 0);
    addv(4'b0000, 0, 1, 1, 0, 1, 0);
    addv(4'b0000, 0, 0, 1, 0, 1, 0);
    addv(4'b0000, 0, 1, 0, 0, 1, 0);
    addv(4'b0000, 0, 1, 0, 0, 1, 0);
    for (int f = 1; f <= 12; f++) begin
      addv((f >= 5) ? 4'b0010 : 4'b0000, 1, 0, 0, (f >= 5) ? 3'd1 : 3'd0, (f < 12) ? 1'b1 : 1'b0, 0);
    end
    addv(4'b0010, 0, 0, 1, 0, 1, 0);

    foreach (tbl[i]) begin
      step(tbl[i].req, tbl[i].fe, tbl[i].lz);
      chk($sformatf("v%0d trig", i), snare_trigger, tbl[i].trig);
      chk($sformatf("v%0d pend", i), pending_count, tbl[i].pend);
      chk($sformatf("v%0d busy", i), busy, tbl[i].busy);
      chk($sformatf("v%0d ovf", i), overflow, tbl[i].ovf);
    end
    pulse_body(4'b0010);
    step(4'b0000, 1'b0, 1'b0);
    chk("table end busy", busy, 0);

`ifndef SFX_COALESCE_EN
    // Four simultaneous edges: four pulses, no overflow.
    p0 = pulse_cnt;
    o0 = ovf_cnt;
    step(4'b1111, 1'b0, 1'b0);
    chk("burst pend", pending_count, 4);
    chk("burst ovf", overflow, 0);
    for (int p = 0; p < 4; p++) begin
      issue(4'b1111, 3 - p);
      pulse_body(4'b1111);
    end
    step(4'b0000, 1'b0, 1'b0);
    chk("burst idle trig", snare_trigger, 0);
    chk("burst idle pend", pending_count, 0);
    chk("burst pulses", pulse_cnt - p0, 4);
    chk("burst ovf count", ovf_cnt - o0, 0);

    // Six edges during one GAP: saturate at 4, two overflow pulses.
    step(4'b0001, 1'b0, 1'b0);
    issue(4'b0001, 0);
    for (int l = 0; l < 4; l++) step(4'b0001, 1'b0, 1'b1);
    chk("ovf in gap", snare_trigger, 0);
    o0 = ovf_cnt;
    for (int k = 1; k <= 6; k++) begin
      step(4'b0000, 1'b0, 1'b0);
      chk($sformatf("ovf k%0d quiet", k), overflow, 0);
      step(4'b0001, 1'b0, 1'b0);
      chk($sformatf("ovf k%0d pend", k), pending_count, (k > 4) ? 4 : k);
      chk($sformatf("ovf k%0d flag", k), overflow, (k > 4) ? 1 : 0);
    end
    for (int f = 0; f < 12; f++) step(4'b0001, 1'b1, 1'b0);
    chk("ovf gap done", busy, 0);
    p0 = pulse_cnt;
    for (int p = 0; p < 4; p++) begin
      issue(4'b0001, 3 - p);
      pulse_body(4'b0001);
    end
    step(4'b0000, 1'b0, 1'b0);
    chk("ovf pulses", pulse_cnt - p0, 4);
    chk("ovf count", ovf_cnt - o0, 2);
`else
    // Edges during HOLD are dropped; GAP edges merge into one pending request.
    p0 = pulse_cnt;
    o0 = ovf_cnt;
    step(4'b0001, 1'b0, 1'b0);
    issue(4'b0001, 0);
    step(4'b0011, 1'b0, 1'b0);
    chk("coal hold e1", pending_count, 0);
    step(4'b0111, 1'b0, 1'b1);
    chk("coal hold e2", pending_count, 0);
    step(4'b1111, 1'b0, 1'b0);
    chk("coal hold e3", pending_count, 0);
    for (int l = 0; l < 3; l++) step(4'b1111, 1'b0, 1'b1);
    chk("coal gap trig", snare_trigger, 0);
    step(4'b1110, 1'b0, 1'b0);
    step(4'b1111, 1'b0, 1'b0);
    chk("coal gap e1", pending_count, 1);
    step(4'b1110, 1'b0, 1'b0);
    step(4'b1111, 1'b0, 1'b0);
    chk("coal gap e2", pending_count, 1);
    for (int f = 0; f < 12; f++) step(4'b1111, 1'b1, 1'b0);
    issue(4'b1111, 0);
    pulse_body(4'b1111);
    step(4'b0000, 1'b0, 1'b0);
    chk("coal pulses", pulse_cnt - p0, 2);
    chk("coal ovf count", ovf_cnt - o0, 0);
    chk("coal max pend", max_pend, 1);
`endif

    // A level held for 1000 cycles is one request.
    step(4'b0000, 1'b0, 1'b0);
    p0 = pulse_cnt;
    for (int c = 0; c < 1000; c++) begin
      step(4'b0100, (c % 20) == 19, (c % 4) == 0);
    end
    chk("held pulses", pulse_cnt - p0, 1);
    chk("held pend", pending_count, 0);
    chk("held busy", busy, 0);
    step(4'b0000, 1'b0, 1'b0);

    // Asynchronous reset in the middle of HOLD with requests queued.
    step(4'b0111, 1'b0, 1'b0);
`ifndef SFX_COALESCE_EN
    chk("rst pre pend", pending_count, 3);
    issue(4'b0111, 2);
`else
    chk("rst pre pend", pending_count, 1);
    issue(4'b0111, 0);
`endif
    step(4'b0111, 1'b0, 1'b1);
    step(4'b0111, 1'b0, 1'b0);
    #2;
    reset     = 1'b1;
    event_req = 4'b0000;
    #1;
    chk("async rst trig", snare_trigger, 0);
    chk("async rst busy", busy, 0);
    chk("async rst pend", pending_count, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    p0 = pulse_cnt;
    for (int c = 0; c < 40; c++) begin
      step(4'b0000, (c % 5) == 4, (c % 3) == 0);
    end
    chk("post rst pulses", pulse_cnt - p0, 0);
    chk("post rst pend", pending_count, 0);
    chk("post rst busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
